// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-memory port between NUM_REQ requesters.
// Routes read data back to the issuer; optional lock for atomic sequences.
module bram_port_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int CAPACITY_BYTES = 128,
  parameter  int BYTES_PER_WORD = 4,
  localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES),
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD,
  localparam int PW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ-1:0]                       req_lock,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]        req_address,
  input  logic [NUM_REQ-1:0]                       req_rd_en,
  input  logic [NUM_REQ-1:0][BYTES_PER_WORD-1:0]   req_wr_en,
  input  logic [NUM_REQ-1:0][WORD_BITS-1:0]        req_wr_data,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic [WORD_BITS-1:0]                     rsp_data,
  output logic [ADDR_BITS-1:0]                     mem_address,
  output logic                                     mem_rd_en,
  output logic [BYTES_PER_WORD-1:0]                mem_wr_en,
  output logic [WORD_BITS-1:0]                     mem_wr_data,
  input  logic [WORD_BITS-1:0]                     mem_rd_data
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gidx;
  logic               found;
  logic [PW-1:0]      cand;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    if (found) begin
      rr_ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + PW'(1);
      if (req_rd_en[gidx]) rsp_valid_d = grant;
      unique case (state_q)
        IDLE: begin
          if (req_lock[gidx]) begin
            state_d = LOCKED;
            owner_d = gidx;
          end
        end
        LOCKED: begin
          if (!req_lock[gidx]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Grant search; a locked port only ever looks at its owner
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    if (reset_n) begin
      if (state_q == LOCKED) begin
        if (req_valid[owner_q]) begin
          grant[owner_q] = 1'b1;
          gidx           = owner_q;
          found          = 1'b1;
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          cand = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
          if (!found && req_valid[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready   = grant;
    mem_address = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = '0;
    mem_wr_data = '0;
    if (found) begin
      mem_address = req_address[gidx];
      mem_rd_en   = req_rd_en[gidx];
      mem_wr_en   = req_wr_en[gidx];
      mem_wr_data = req_wr_data[gidx];
    end
    rsp_valid = rsp_valid_q;
    rsp_data  = (|rsp_valid_q) ? mem_rd_data : '0;
  end

endmodule
